// File: rtl/design_select_sequencer.sv
// rtl/design_select_sequencer.sv - filtered design select with isolate/reset/settle switch sequencing
module design_select_sequencer #(
    parameter int NUM_DESIGNS   = 12,
    parameter int GPIO_W        = 34,
    parameter int STABLE_CYCLES = 4,
    parameter int ISO_CYCLES    = 2,
    parameter int RST_CYCLES    = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             sel_req,
    input  logic [GPIO_W-1:0]      gpio_oeb_in,
    output logic [GPIO_W-1:0]      gpio_oeb_out,
    output logic [3:0]             active_sel,
    output logic                   active_valid,
    output logic [NUM_DESIGNS-1:0] design_en,
    output logic                   design_rst,
    output logic                   busy,
    output logic                   switch_done
);

    localparam int PH_MAX_A = (ISO_CYCLES > RST_CYCLES) ? ISO_CYCLES : RST_CYCLES;
    localparam int PH_MAX   = (PH_MAX_A > SETTLE_CYCLES) ? PH_MAX_A : SETTLE_CYCLES;
    localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [PH_W-1:0]  ISO_LAST    = PH_W'(ISO_CYCLES - 1);
    localparam logic [PH_W-1:0]  RST_LAST    = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ISOLATE = 2'd1,
        ST_RESET   = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [3:0]       target;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             stable;
    logic             oeb_force;

    // Stability is judged on the count after this sample, so the Nth equal
    // sample triggers the switch on its own edge.
    always_comb begin
        cnt_next = cnt;
        if (sel_req != cand) begin
            cnt_next = '0;
        end else if (cnt != CNT_LAST) begin
            cnt_next = cnt + 1'b1;
        end
    end

    assign stable = (sel_req == cand) && (cnt_next == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RESET;
            phase        <= '0;
            target       <= '0;
            cand         <= '0;
            cnt          <= '0;
            active_sel   <= '0;
            active_valid <= 1'b1;
            design_rst   <= 1'b1;
            oeb_force    <= 1'b1;
            busy         <= 1'b1;
            switch_done  <= 1'b0;
        end else begin
            cand        <= sel_req;
            cnt         <= cnt_next;
            switch_done <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (stable && (sel_req != active_sel)) begin
                        target     <= sel_req;
                        state      <= ST_ISOLATE;
                        phase      <= '0;
                        busy       <= 1'b1;
                        oeb_force  <= 1'b1;
                        design_rst <= 1'b0;
                    end
                end
                ST_ISOLATE: begin
                    if (phase == ISO_LAST) begin
                        active_sel   <= target;
                        active_valid <= (int'(target) < NUM_DESIGNS);
                        state        <= ST_RESET;
                        phase        <= '0;
                        design_rst   <= 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_RESET: begin
                    if (phase == RST_LAST) begin
                        state      <= ST_SETTLE;
                        phase      <= '0;
                        design_rst <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (phase == SETTLE_LAST) begin
                        state       <= ST_RUN;
                        phase       <= '0;
                        busy        <= 1'b0;
                        switch_done <= 1'b1;
                        // A parked code keeps pads isolated and the slot in reset.
                        oeb_force   <= ~active_valid;
                        design_rst  <= ~active_valid;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= ST_RESET;
                    phase <= '0;
                end
            endcase
        end
    end

    assign gpio_oeb_out = oeb_force ? {GPIO_W{1'b1}} : gpio_oeb_in;
    assign design_en    = active_valid ? (NUM_DESIGNS'(1) << active_sel) : '0;

endmodule

// File: tb/tb_design_select_sequencer.sv
// tb/tb_design_select_sequencer.sv - scoreboard bench for design_select_sequencer
module tb_design_select_sequencer;

    localparam int GPIO_W = 34;
    localparam logic [GPIO_W-1:0] ALL_IN = {GPIO_W{1'b1}};

    typedef struct packed {
        logic [3:0]  sel;
        logic        valid;
        logic [11:0] en;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        sel_req;
    logic [GPIO_W-1:0] gpio_oeb_in;
    logic [GPIO_W-1:0] gpio_oeb_out;
    logic [3:0]        active_sel;
    logic              active_valid;
    logic [11:0]       design_en;
    logic              design_rst;
    logic              busy;
    logic              switch_done;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    design_select_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .sel_req     (sel_req),
        .gpio_oeb_in (gpio_oeb_in),
        .gpio_oeb_out(gpio_oeb_out),
        .active_sel  (active_sel),
        .active_valid(active_valid),
        .design_en   (design_en),
        .design_rst  (design_rst),
        .busy        (busy),
        .switch_done (switch_done)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every completed switch must match the oldest expected selection.
    always @(posedge clk) begin
        #2;
        if (switch_done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: active_sel=%0d but no switch was expected", active_sel);
            end else begin
                mon_e = exp_q.pop_front();
                if ({active_sel, active_valid, design_en} !== {mon_e.sel, mon_e.valid, mon_e.en}) begin
                    errors++;
                    $display("FAIL sb_switch: got sel=%0d valid=%0b en=%h, expected sel=%0d valid=%0b en=%h",
                             active_sel, active_valid, design_en, mon_e.sel, mon_e.valid, mon_e.en);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (switch_done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (switch_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: switch_done=%b after %0d cycles, expected 1", tag, switch_done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sel_req = 4'd0;
        gpio_oeb_in = '0;
        exp_q.push_back('{sel: 4'd0, valid: 1'b1, en: 12'h001});
        repeat (3) tick();
        checks++;
        if ({active_sel, active_valid, design_en, design_rst, busy, switch_done, gpio_oeb_out} !==
            {4'd0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b0, ALL_IN}) begin
            errors++;
            $display("FAIL reset_values: sel=%0d valid=%b en=%h rst=%b busy=%b done=%b oeb=%h",
                     active_sel, active_valid, design_en, design_rst, busy, switch_done, gpio_oeb_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (design_rst !== (i < 8) || gpio_oeb_out !== ALL_IN || busy !== 1'b1 || switch_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_seq_cycle%0d: design_rst=%b oeb=%h busy=%b done=%b, expected rst=%b oeb all 1 busy=1 done=0",
                         i, design_rst, gpio_oeb_out, busy, switch_done, (i < 8));
            end
            tick();
        end
        checks++;
        if (switch_done !== 1'b1 || busy !== 1'b0 || design_rst !== 1'b0 || gpio_oeb_out !== gpio_oeb_in) begin
            errors++;
            $display("FAIL reset_run_entry: done=%b busy=%b rst=%b oeb=%h, expected 1 0 0 %h",
                     switch_done, busy, design_rst, gpio_oeb_out, gpio_oeb_in);
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 9; i++) begin
            sel_req = (i < 3) ? 4'd3 : 4'd0;
            gpio_oeb_in = GPIO_W'({$urandom(), $urandom()});
            #1;
            checks++;
            if (busy !== 1'b0 || active_sel !== 4'd0 || gpio_oeb_out !== gpio_oeb_in) begin
                errors++;
                $display("FAIL glitch_cycle%0d: busy=%b sel=%0d oeb=%h, expected busy=0 sel=0 oeb=%h",
                         i, busy, active_sel, gpio_oeb_out, gpio_oeb_in);
            end
            tick();
        end
    endtask

    task automatic test_clean_switch();
        int n = 0;
        gpio_oeb_in = '0;
        sel_req = 4'd5;
        exp_q.push_back('{sel: 4'd5, valid: 1'b1, en: 12'h020});
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_early_busy: busy=%b 3 cycles after request, expected 0", busy);
        end
        tick();
        while (busy === 1'b1 && n < 20) begin
            checks++;
            if (gpio_oeb_out !== ALL_IN || design_rst !== (n >= 2 && n < 10) ||
                active_sel !== ((n >= 2) ? 4'd5 : 4'd0)) begin
                errors++;
                $display("FAIL clean_busy_cycle%0d: oeb=%h rst=%b sel=%0d, expected oeb all 1 rst=%b sel=%0d",
                         n, gpio_oeb_out, design_rst, active_sel, (n >= 2 && n < 10), (n >= 2) ? 5 : 0);
            end
            n++;
            tick();
        end
        checks++;
        if (n != 12 || switch_done !== 1'b1 || gpio_oeb_out !== gpio_oeb_in) begin
            errors++;
            $display("FAIL clean_busy_len: busy lasted %0d cycles done=%b oeb=%h, expected 12 cycles done=1 oeb=%h",
                     n, switch_done, gpio_oeb_out, gpio_oeb_in);
        end
        tick();
        checks++;
        if (switch_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_done_pulse: done=%b busy=%b one cycle later, expected 0 0", switch_done, busy);
        end
    endtask

    task automatic test_parked();
        sel_req = 4'd14;
        exp_q.push_back('{sel: 4'd14, valid: 1'b0, en: 12'h000});
        wait_done("parked_enter");
        for (int i = 0; i < 3; i++) begin
            gpio_oeb_in = GPIO_W'({$urandom(), $urandom()});
            #1;
            checks++;
            if (gpio_oeb_out !== ALL_IN || design_rst !== 1'b1 || active_valid !== 1'b0 || design_en !== 12'h000) begin
                errors++;
                $display("FAIL parked_run%0d: oeb=%h rst=%b valid=%b en=%h, expected oeb all 1 rst=1 valid=0 en=0",
                         i, gpio_oeb_out, design_rst, active_valid, design_en);
            end
            tick();
        end
        sel_req = 4'd2;
        exp_q.push_back('{sel: 4'd2, valid: 1'b1, en: 12'h004});
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1 || design_rst !== 1'b0 || gpio_oeb_out !== ALL_IN) begin
            errors++;
            $display("FAIL parked_isolate: busy=%b rst=%b oeb=%h, expected 1 0 all 1", busy, design_rst, gpio_oeb_out);
        end
        wait_done("parked_leave");
        gpio_oeb_in = GPIO_W'({$urandom(), $urandom()});
        #1;
        checks++;
        if (gpio_oeb_out !== gpio_oeb_in || design_rst !== 1'b0) begin
            errors++;
            $display("FAIL parked_leave_run: oeb=%h rst=%b, expected oeb=%h rst=0", gpio_oeb_out, design_rst, gpio_oeb_in);
        end
    endtask

    task automatic test_change_during_busy();
        sel_req = 4'd5;
        exp_q.push_back('{sel: 4'd5, valid: 1'b1, en: 12'h020});
        repeat (4) tick();
        repeat (4) tick();
        checks++;
        if (design_rst !== 1'b1 || active_sel !== 4'd5) begin
            errors++;
            $display("FAIL busy_change_reset3: rst=%b sel=%0d, expected rst=1 sel=5", design_rst, active_sel);
        end
        sel_req = 4'd7;
        exp_q.push_back('{sel: 4'd7, valid: 1'b1, en: 12'h080});
        wait_done("busy_change_first");
        checks++;
        if (busy !== 1'b0 || active_sel !== 4'd5) begin
            errors++;
            $display("FAIL busy_change_finish: busy=%b sel=%0d, expected busy=0 sel=5", busy, active_sel);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || switch_done !== 1'b0 || gpio_oeb_out !== ALL_IN || active_sel !== 4'd5) begin
            errors++;
            $display("FAIL busy_change_restart: busy=%b done=%b oeb=%h sel=%0d, expected 1 0 all 1 sel=5",
                     busy, switch_done, gpio_oeb_out, active_sel);
        end
        wait_done("busy_change_second");
    endtask

    task automatic test_reset_mid();
        sel_req = 4'd9;
        exp_q.push_back('{sel: 4'd9, valid: 1'b1, en: 12'h200});
        repeat (6) tick();
        checks++;
        if (active_sel !== 4'd9 || design_rst !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reset0: sel=%0d rst=%b, expected sel=9 rst=1", active_sel, design_rst);
        end
        repeat (2) tick();
        rst = 1'b1;
        void'(exp_q.pop_back());
        exp_q.push_back('{sel: 4'd0, valid: 1'b1, en: 12'h001});
        exp_q.push_back('{sel: 4'd9, valid: 1'b1, en: 12'h200});
        tick();
        checks++;
        if ({active_sel, active_valid, design_en, design_rst, busy, switch_done} !==
            {4'd0, 1'b1, 12'h001, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_values: sel=%0d valid=%b en=%h rst=%b busy=%b done=%b, expected 0 1 001 1 1 0",
                     active_sel, active_valid, design_en, design_rst, busy, switch_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (design_rst !== (i < 8) || gpio_oeb_out !== ALL_IN || busy !== 1'b1 || active_sel !== 4'd0) begin
                errors++;
                $display("FAIL rstmid_seq_cycle%0d: rst=%b oeb=%h busy=%b sel=%0d, expected rst=%b oeb all 1 busy=1 sel=0",
                         i, design_rst, gpio_oeb_out, busy, active_sel, (i < 8));
            end
            tick();
        end
        checks++;
        if (switch_done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done: switch_done=%b at post-reset cycle 10, expected 1", switch_done);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reaccept: busy=%b after first RUN cycle, expected 1", busy);
        end
        wait_done("rstmid_final");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_switch();
        test_parked();
        test_change_during_busy();
        test_reset_mid();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected switches never completed, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
